// File: rtl/tmds_symbol_decoder.sv
// tmds_symbol_decoder: TMDS 10b->8b decode with control-token word alignment, bit-slip search and lock tracking
module tmds_symbol_decoder #(
    parameter int LOCK_RUN = 16,
    parameter int SEARCH_WIN = 2048,
    parameter int GAP_MAX = 4096
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       sym_valid,
    input  logic [9:0] sym_in,
    output logic       out_valid,
    output logic [7:0] data_out,
    output logic [1:0] ctrl_out,
    output logic       de_out,
    output logic       locked,
    output logic       bitslip
);
    localparam int SLIP_LEN = 16;
    localparam int RW = $clog2(LOCK_RUN + 1);
    localparam int WW = $clog2(SEARCH_WIN + 1);
    localparam int GW = $clog2(GAP_MAX + 1);
    localparam int SW = $clog2(SLIP_LEN + 1);
    localparam logic [9:0] T00 = 10'b1101010100;
    localparam logic [9:0] T01 = 10'b0010101011;
    localparam logic [9:0] T10 = 10'b0101010100;
    localparam logic [9:0] T11 = 10'b1010101011;

    typedef enum logic [1:0] {SEARCH, SLIP_WAIT, LOCKED} state_t;

    state_t state, state_nxt;
    logic [RW-1:0] run, run_nxt;
    logic [WW-1:0] win, win_nxt;
    logic [GW-1:0] gap, gap_nxt;
    logic [SW-1:0] slip, slip_nxt;
    logic slip_req, is_tok, take;
    logic [1:0] tok_val;
    logic [7:0] q, x, dec;

    assign is_tok = (sym_in == T00) || (sym_in == T01) || (sym_in == T10) || (sym_in == T11);
    assign tok_val = {(sym_in == T10) || (sym_in == T11), (sym_in == T01) || (sym_in == T11)};
    assign q = sym_in[9] ? ~sym_in[7:0] : sym_in[7:0];
    assign x = q ^ {q[6:0], 1'b0};
    assign dec = {sym_in[8] ? x[7:1] : ~x[7:1], q[0]};
    assign take = sym_valid && (state == LOCKED);
    assign locked = (state == LOCKED);

    always_comb begin
        state_nxt = state;
        run_nxt = run;
        win_nxt = win;
        gap_nxt = gap;
        slip_nxt = slip;
        slip_req = 1'b0;
        if (sym_valid) begin
            case (state)
                SEARCH: begin
                    run_nxt = !is_tok ? '0 : (run == RW'(LOCK_RUN)) ? run : run + RW'(1);
                    win_nxt = (win == WW'(SEARCH_WIN)) ? win : win + WW'(1);
                    if (is_tok && run >= RW'(LOCK_RUN - 1)) begin
                        state_nxt = LOCKED;
                        run_nxt = '0;
                        win_nxt = '0;
                    end else if (win >= WW'(SEARCH_WIN - 1)) begin
                        state_nxt = SLIP_WAIT;
                        slip_req = 1'b1;
                        run_nxt = '0;
                        win_nxt = '0;
                    end
                end
                SLIP_WAIT: begin
                    state_nxt = (slip >= SW'(SLIP_LEN - 1)) ? SEARCH : SLIP_WAIT;
                    slip_nxt = (slip >= SW'(SLIP_LEN - 1)) ? '0 : slip + SW'(1);
                end
                LOCKED: begin
                    state_nxt = (!is_tok && gap >= GW'(GAP_MAX - 1)) ? SEARCH : LOCKED;
                    gap_nxt = (is_tok || gap >= GW'(GAP_MAX - 1)) ? '0 : gap + GW'(1);
                end
                default: state_nxt = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state <= SEARCH;
            run <= '0;
            win <= '0;
            gap <= '0;
            slip <= '0;
            out_valid <= 1'b0;
            data_out <= '0;
            ctrl_out <= '0;
            de_out <= 1'b0;
            bitslip <= 1'b0;
        end else begin
            state <= state_nxt;
            run <= run_nxt;
            win <= win_nxt;
            gap <= gap_nxt;
            slip <= slip_nxt;
            out_valid <= take;
            bitslip <= slip_req;
            if (take) begin
                de_out <= !is_tok;
                data_out <= is_tok ? data_out : dec;
                ctrl_out <= is_tok ? tok_val : ctrl_out;
            end
        end
    end
endmodule

// File: tb/tb_tmds_symbol_decoder.sv
// tb_tmds_symbol_decoder: randomized self-checking bench with a DVI encoder and scenario-level expectations
module tb_tmds_symbol_decoder;
    logic clk_in = 1'b0;
    logic rst_in;
    logic sym_valid;
    logic [9:0] sym_in;
    logic out_valid;
    logic [7:0] data_out;
    logic [1:0] ctrl_out;
    logic de_out;
    logic locked;
    logic bitslip;

    int tests = 0;
    int fails = 0;
    int disp = 0;
    logic [9:0] tok [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};

    tmds_symbol_decoder dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .sym_valid(sym_valid),
        .sym_in(sym_in),
        .out_valid(out_valid),
        .data_out(data_out),
        .ctrl_out(ctrl_out),
        .de_out(de_out),
        .locked(locked),
        .bitslip(bitslip)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic is_tok(input logic [9:0] s);
        return s == tok[0] || s == tok[1] || s == tok[2] || s == tok[3];
    endfunction

    function automatic logic [9:0] rand_data();
        logic [9:0] s;
        do s = 10'($urandom); while (is_tok(s));
        return s;
    endfunction

    function automatic logic [9:0] encode(input logic [7:0] d);
        logic [8:0] qm;
        logic [9:0] s;
        int n1, n1q, n0q, b;
        logic use_xnor;
        n1 = $countones(d);
        use_xnor = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = !use_xnor;
        b = int'(qm[8]);
        n1q = $countones(qm[7:0]);
        n0q = 8 - n1q;
        if (disp == 0 || n1q == n0q) begin
            s = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            disp += b ? (n1q - n0q) : (n0q - n1q);
        end else if ((disp > 0 && n1q > n0q) || (disp < 0 && n0q > n1q)) begin
            s = {1'b1, qm[8], ~qm[7:0]};
            disp += 2 * b + n0q - n1q;
        end else begin
            s = {1'b0, qm[8], qm[7:0]};
            disp += -2 * (1 - b) + n1q - n0q;
        end
        return s;
    endfunction

    task automatic push(input logic [9:0] s, input logic v);
        sym_in = s;
        sym_valid = v;
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        sym_valid = 1'b0;
        sym_in = '0;
        @(negedge clk_in);
        rst_in = 1'b0;
        @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        sym_valid = 1'b0;
        sym_in = '0;
        #3;
        tests++;
        if ({out_valid, data_out, ctrl_out, de_out, locked, bitslip} !== 14'd0) begin
            fails++;
            $display("FAIL reset_initial outputs=%b exp=0", {out_valid, data_out, ctrl_out, de_out, locked, bitslip});
        end
        push(tok[0], 1'b1);
        tests++;
        if ({out_valid, data_out, ctrl_out, de_out, locked, bitslip} !== 14'd0) begin
            fails++;
            $display("FAIL reset_held outputs=%b exp=0", {out_valid, data_out, ctrl_out, de_out, locked, bitslip});
        end
        #2 rst_in = 1'b1;
    endtask

    task automatic test_lock();
        for (int i = 1; i <= 16; i++) begin
            push(tok[0], 1'b1);
            tests++;
            if (locked !== (i == 16) || out_valid !== 1'b0) begin
                fails++;
                $display("FAIL lock_run i=%0d locked=%b out_valid=%b exp_locked=%b", i, locked, out_valid, i == 16);
            end
        end
        push(10'b0100000000, 1'b1);
        tests++;
        if (out_valid !== 1'b1 || de_out !== 1'b1 || data_out !== 8'h00 || locked !== 1'b1) begin
            fails++;
            $display("FAIL lock_first_data ov=%b de=%b data=%h locked=%b exp 1 1 00 1", out_valid, de_out, data_out, locked);
        end
    endtask

    task automatic test_tokens();
        disp = 0;
        push(encode(8'hA5), 1'b1);
        tests++;
        if (data_out !== 8'hA5 || de_out !== 1'b1) begin
            fails++;
            $display("FAIL tokens_pre data=%h de=%b exp a5 1", data_out, de_out);
        end
        for (int k = 0; k < 4; k++) begin
            push(tok[k], 1'b1);
            tests++;
            if (ctrl_out !== 2'(k) || de_out !== 1'b0 || data_out !== 8'hA5 || out_valid !== 1'b1) begin
                fails++;
                $display("FAIL token k=%0d ctrl=%b de=%b data=%h ov=%b exp ctrl=%0d de=0 data=a5 ov=1", k, ctrl_out, de_out, data_out, out_valid, k);
            end
        end
    endtask

    task automatic test_bytes();
        logic [7:0] exp_data = 8'hA5;
        logic exp_de = 1'b0;
        disp = 0;
        for (int b = 0; b < 256; b++) begin
            if ($urandom_range(3) == 0) begin
                push(rand_data(), 1'b0);
                tests++;
                if (out_valid !== 1'b0 || data_out !== exp_data || de_out !== exp_de || ctrl_out !== 2'b11) begin
                    fails++;
                    $display("FAIL idle_hold b=%0d ov=%b data=%h de=%b ctrl=%b exp 0 %h %b 11", b, out_valid, data_out, de_out, ctrl_out, exp_data, exp_de);
                end
            end
            push(encode(8'(b)), 1'b1);
            exp_data = 8'(b);
            exp_de = 1'b1;
            tests++;
            if (out_valid !== 1'b1 || data_out !== exp_data || de_out !== 1'b1 || ctrl_out !== 2'b11) begin
                fails++;
                $display("FAIL byte b=%0d ov=%b data=%h de=%b ctrl=%b exp 1 %h 1 11", b, out_valid, data_out, de_out, ctrl_out, exp_data);
            end
        end
    endtask

    task automatic test_gap();
        push(tok[0], 1'b1);
        for (int i = 0; i < 4000; i++) push(rand_data(), 1'b1);
        push(tok[1], 1'b1);
        for (int i = 1; i <= 4095; i++) begin
            push(rand_data(), 1'b1);
            tests++;
            if (locked !== 1'b1 || out_valid !== 1'b1) begin
                fails++;
                $display("FAIL gap_hold i=%0d locked=%b ov=%b exp 1 1", i, locked, out_valid);
            end
        end
        push(rand_data(), 1'b1);
        tests++;
        if (locked !== 1'b0) begin
            fails++;
            $display("FAIL gap_drop locked=%b exp 0", locked);
        end
        push(rand_data(), 1'b1);
        tests++;
        if (out_valid !== 1'b0 || locked !== 1'b0) begin
            fails++;
            $display("FAIL gap_after ov=%b locked=%b exp 0 0", out_valid, locked);
        end
    endtask

    task automatic test_search();
        logic [9:0] s;
        int run = 0;
        do_reset();
        for (int i = 1; i <= 2048; i++) begin
            if ($urandom_range(7) == 0) begin
                push(tok[0], 1'b0);
                tests++;
                if (bitslip !== 1'b0) begin
                    fails++;
                    $display("FAIL search_idle i=%0d bitslip=%b exp 0", i, bitslip);
                end
            end
            s = (run < 15 && $urandom_range(3) == 0) ? tok[$urandom_range(3)] : rand_data();
            run = is_tok(s) ? run + 1 : 0;
            push(s, 1'b1);
            tests++;
            if (bitslip !== (i == 2048) || locked !== 1'b0) begin
                fails++;
                $display("FAIL search i=%0d bitslip=%b locked=%b exp %b 0", i, bitslip, locked, i == 2048);
            end
        end
        push(tok[0], 1'b0);
        tests++;
        if (bitslip !== 1'b0) begin
            fails++;
            $display("FAIL slip_pulse_width bitslip=%b exp 0", bitslip);
        end
        for (int i = 1; i <= 16; i++) begin
            push(tok[0], 1'b1);
            tests++;
            if (bitslip !== 1'b0 || locked !== 1'b0) begin
                fails++;
                $display("FAIL slip_wait i=%0d bitslip=%b locked=%b exp 0 0", i, bitslip, locked);
            end
        end
        for (int i = 1; i <= 16; i++) begin
            push(tok[0], 1'b1);
            tests++;
            if (locked !== (i == 16)) begin
                fails++;
                $display("FAIL relock_after_slip i=%0d locked=%b exp %b", i, locked, i == 16);
            end
        end
    endtask

    task automatic test_priority();
        do_reset();
        for (int i = 0; i < 2032; i++) push(rand_data(), 1'b1);
        for (int i = 1; i <= 16; i++) begin
            push(tok[2], 1'b1);
            tests++;
            if (bitslip !== 1'b0 || locked !== (i == 16)) begin
                fails++;
                $display("FAIL lock_priority i=%0d bitslip=%b locked=%b exp 0 %b", i, bitslip, locked, i == 16);
            end
        end
    endtask

    task automatic test_reset_midlock();
        push(encode(8'h3C), 1'b1);
        tests++;
        if (out_valid !== 1'b1 || de_out !== 1'b1 || data_out !== 8'h3C || locked !== 1'b1) begin
            fails++;
            $display("FAIL midlock_pre ov=%b de=%b data=%h locked=%b exp 1 1 3c 1", out_valid, de_out, data_out, locked);
        end
        #2 rst_in = 1'b0;
        #1;
        tests++;
        if (locked !== 1'b0 || out_valid !== 1'b0 || de_out !== 1'b0 || data_out !== 8'h00) begin
            fails++;
            $display("FAIL midlock_reset locked=%b ov=%b de=%b data=%h exp 0 0 0 00", locked, out_valid, de_out, data_out);
        end
        #1 rst_in = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            push(tok[3], 1'b1);
            tests++;
            if (locked !== (i == 16)) begin
                fails++;
                $display("FAIL midlock_relock i=%0d locked=%b exp %b", i, locked, i == 16);
            end
        end
    endtask

    task automatic test_reset_midslip();
        do_reset();
        for (int i = 0; i < 2047; i++) push(rand_data(), 1'b1);
        push(rand_data(), 1'b1);
        tests++;
        if (bitslip !== 1'b1) begin
            fails++;
            $display("FAIL midslip_pulse bitslip=%b exp 1", bitslip);
        end
        #1 rst_in = 1'b0;
        #1;
        tests++;
        if (bitslip !== 1'b0) begin
            fails++;
            $display("FAIL midslip_cancel bitslip=%b exp 0", bitslip);
        end
        #1 rst_in = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            push(tok[1], 1'b1);
            tests++;
            if (locked !== (i == 16) || bitslip !== 1'b0) begin
                fails++;
                $display("FAIL midslip_search i=%0d locked=%b bitslip=%b exp %b 0", i, locked, bitslip, i == 16);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_tokens();
        test_bytes();
        test_gap();
        test_search();
        test_priority();
        test_reset_midlock();
        test_reset_midslip();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
